// File: rtl/sonar_pkg.sv
// Shared DSP constants for the sonar signal chain (PDM front end, CIC, PCM width).
package sonar_pkg;

  localparam int CIC_ORDER = 3;
  localparam int PDM_DIV   = 16;
  localparam int PDM_DECIM = 64;
  localparam int PCM_W     = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Worst-case CIC growth plus sign and the +/-1 input mapping.
  function automatic int cicAccW(input int decim);
    return 2 + CIC_ORDER * clog2(decim);
  endfunction

endpackage

// File: rtl/pdm_clkgen.sv
// Microphone bit-clock generator: divides clk48 down to pdwClk and flags the
// last cycle of each low phase, where PDM data is sampled.
module pdm_clkgen
  import sonar_pkg::*;
#(
  parameter int CLK_DIV = PDM_DIV
) (
  input  logic clk48,
  input  logic rstN,
  input  logic enable,
  output logic pdwClk,
  output logic bitTick
);

  localparam int CNT_W = clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FALL = CNT_W'(CLK_DIV / 2 - 1);

  logic [CNT_W-1:0] divCnt;

  always_ff @(posedge clk48 or negedge rstN) begin
    if (!rstN) begin
      divCnt <= '0;
      pdwClk <= 1'b0;
    end else if (!enable) begin
      divCnt <= '0;
      pdwClk <= 1'b0;
    end else if (divCnt == CNT_LAST) begin
      divCnt <= '0;
      pdwClk <= 1'b1;
    end else begin
      divCnt <= divCnt + 1'b1;
      if (divCnt == CNT_FALL) pdwClk <= 1'b0;
    end
  end

  // Data is stable here: the mic changed it half a period ago on the falling edge.
  assign bitTick = enable && (divCnt == CNT_LAST);

endmodule

// File: rtl/pdm_cic_decimator.sv
// PDM-to-PCM converter: 3rd-order CIC (integrators at bit rate, combs at the
// decimated rate) with arithmetic scaling and saturation to OUT_W bits.
module pdm_cic_decimator
  import sonar_pkg::*;
#(
  parameter int CLK_DIV = PDM_DIV,
  parameter int DECIM   = PDM_DECIM,
  parameter int OUT_W   = PCM_W
) (
  input  logic             clk48,
  input  logic             rstN,
  input  logic             enable,
  output logic             pdwClk,
  input  logic             pdwData,
  output logic [OUT_W-1:0] sample,
  output logic             sampleValid
);

  localparam int ORDER = CIC_ORDER;
  localparam int DEC_W = clog2(DECIM);
  localparam int ACC_W = cicAccW(DECIM);
  localparam int SHIFT = ACC_W - OUT_W - 1;
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);
  localparam int SAT_HI_I = (1 << (OUT_W - 1)) - 1;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(SAT_HI_I);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-SAT_HI_I - 1);

  logic bitTick;
  logic tickReg;
  logic dataReg;
  logic [ACC_W-1:0] xVal;

  pdm_clkgen #(.CLK_DIV(CLK_DIV)) uClkgen (
    .clk48  (clk48),
    .rstN   (rstN),
    .enable (enable),
    .pdwClk (pdwClk),
    .bitTick(bitTick)
  );

  always_ff @(posedge clk48 or negedge rstN) begin
    if (!rstN) begin
      tickReg <= 1'b0;
      dataReg <= 1'b0;
    end else if (!enable) begin
      tickReg <= 1'b0;
      dataReg <= 1'b0;
    end else begin
      tickReg <= bitTick;
      if (bitTick) dataReg <= pdwData;
    end
  end

  assign xVal = {{(ACC_W-1){~dataReg}}, 1'b1};

  // Integrators wrap freely; the comb differences remain exact modulo 2^ACC_W.
  logic [ACC_W-1:0] integ     [ORDER];
  logic [ACC_W-1:0] integNext [ORDER];

  for (genvar gi = 0; gi < ORDER; gi++) begin : gInteg
    logic [ACC_W-1:0] accReg;
    if (gi == 0) begin : gFirst
      assign integNext[gi] = accReg + xVal;
    end else begin : gRest
      assign integNext[gi] = accReg + integ[gi-1];
    end
    always_ff @(posedge clk48 or negedge rstN) begin
      if (!rstN) accReg <= '0;
      else if (!enable) accReg <= '0;
      else if (tickReg) accReg <= integNext[gi];
    end
    assign integ[gi] = accReg;
  end

  logic [DEC_W-1:0] decCnt;
  logic [ACC_W-1:0] latchReg;
  logic             latchValid;

  always_ff @(posedge clk48 or negedge rstN) begin
    if (!rstN) begin
      decCnt     <= '0;
      latchReg   <= '0;
      latchValid <= 1'b0;
    end else if (!enable) begin
      decCnt     <= '0;
      latchReg   <= '0;
      latchValid <= 1'b0;
    end else begin
      latchValid <= 1'b0;
      if (tickReg) begin
        if (decCnt == DEC_LAST) begin
          decCnt     <= '0;
          latchReg   <= integNext[ORDER-1];
          latchValid <= 1'b1;
        end else begin
          decCnt <= decCnt + 1'b1;
        end
      end
    end
  end

  logic [ACC_W-1:0] combIn   [ORDER];
  logic [ACC_W-1:0] combDiff [ORDER];
  logic [ORDER-1:0] stageValid;

  assign combIn[0]     = latchReg;
  assign stageValid[0] = latchValid;

  for (genvar gi = 0; gi < ORDER; gi++) begin : gComb
    logic [ACC_W-1:0] delayReg;
    assign combDiff[gi] = combIn[gi] - delayReg;
    always_ff @(posedge clk48 or negedge rstN) begin
      if (!rstN) delayReg <= '0;
      else if (!enable) delayReg <= '0;
      else if (stageValid[gi]) delayReg <= combIn[gi];
    end
    // The last stage feeds the output register directly, so it needs no pipeline flop.
    if (gi < ORDER - 1) begin : gPipe
      logic [ACC_W-1:0] diffReg;
      logic             validReg;
      always_ff @(posedge clk48 or negedge rstN) begin
        if (!rstN) begin
          diffReg  <= '0;
          validReg <= 1'b0;
        end else if (!enable) begin
          diffReg  <= '0;
          validReg <= 1'b0;
        end else begin
          validReg <= stageValid[gi];
          if (stageValid[gi]) diffReg <= combDiff[gi];
        end
      end
      assign combIn[gi+1]     = diffReg;
      assign stageValid[gi+1] = validReg;
    end
  end

  logic signed [ACC_W-1:0] scaled;
  logic [OUT_W-1:0]        satSample;

  assign scaled = $signed(combDiff[ORDER-1]) >>> SHIFT;

  always_comb begin
    satSample = scaled[OUT_W-1:0];
    if (scaled > SAT_HI) satSample = SAT_HI[OUT_W-1:0];
    else if (scaled < SAT_LO) satSample = SAT_LO[OUT_W-1:0];
  end

  always_ff @(posedge clk48 or negedge rstN) begin
    if (!rstN) begin
      sample      <= '0;
      sampleValid <= 1'b0;
    end else if (!enable) begin
      sampleValid <= 1'b0;
    end else begin
      sampleValid <= stageValid[ORDER-1];
      if (stageValid[ORDER-1]) sample <= satSample;
    end
  end

endmodule

// File: doc/pdm_cic_decimator.md
# pdm_cic_decimator

- Converts the 1-bit PDM stream from the microphone into 16-bit signed PCM samples.
- Generates the microphone bit clock `pdwClk` from `clk48`, samples `pdwData`, and decimates through a 3rd-order CIC filter.
- Sits directly downstream of the microphone pins in TOP. Its PCM output feeds the PWM/speaker path and the sonar correlator.
- Default rates: 3 MHz bit clock, 46.875 kHz output samples.

## Interface
Parameters:
- CLK_DIV, 16: clk48 cycles per pdwClk period; even, ≥4.
- DECIM, 64: PDM bits per output sample; power of two.
- OUT_W, 16: output sample width.
- Derived constants: ORDER = 3 (fixed); ACC_W = 2 + ORDER*log2(DECIM) = 20.

Ports:
- clk48  in  1  sole clock, 48 MHz.
- rstN  in  1  reset, asynchronous, active-low.
- enable  in  1  run; low holds the block idle and cleared.
- pdwClk  out  1  PDM bit clock to the microphone.
- pdwData  in  1  PDM data; the mic changes it after the pdwClk falling edge.
- sample  out  OUT_W  signed PCM sample.
- sampleValid  out  1  one-cycle strobe qualifying `sample`.

## Operation
- **Bit-clock divider.** divCnt counts 0..CLK_DIV-1 while enable=1, then wraps.
  - pdwClk is a register, set on the edge where divCnt wraps to 0 and cleared on the edge where divCnt reaches CLK_DIV/2.
- **Bit tick.** Asserted in the cycle where divCnt == CLK_DIV-1, i.e. the end of the low phase, just before the rising edge. pdwData is captured into a register on that edge.
- **Input mapping.** 1 → +1, 0 → −1, sign-extended to ACC_W.
- **Integrators.** I1..I3 are ACC_W-bit two's-complement registers, updated only on bit ticks: I1+=x, I2+=I1, I3+=I2.
  - Wrap-around is intended and must not be saturated; the CIC is modulo-correct.
- **Decimation.** decCnt counts bit ticks 0..DECIM-1. On the tick where it wraps, I3 is latched and the comb pipeline starts.
- **Combs.** Three stages, C_k = in − delay_k, one stage per clk48 cycle. Each delay_k updates only when its stage fires.
- **Scaling.** result = C3 >>> (ACC_W − OUT_W − 1), then saturated to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - Full-scale all-ones input (+2^18) maps to +32768 and saturates to 32767.
- **Enable low.** Synchronously zeroes divCnt, decCnt, integrators, comb delays and pdwClk, and clears sampleValid.
  - A comb computation already in flight is discarded; no strobe is issued.
- **Reset.** Same cleared state, asynchronous. Release is taken on the next clk48 edge.

## Timing
Reset values:
- pdwClk=0, sample=0, sampleValid=0.
- All counters, integrators and comb delays = 0.

Rates:
- pdwClk period is CLK_DIV cycles with 50% duty.
- sampleValid strobes exactly once every CLK_DIV*DECIM cycles (1024 with defaults). It is never asserted on consecutive cycles.

Latency:
- sampleValid rises 3 cycles after the decimation tick: latch, comb1, comb2, then comb3+saturate into the output register.
- `sample` is held stable until the next strobe.

Start-up:
- First strobe comes CLK_DIV*DECIM + 3 cycles after enable is first sampled high.
- The first two output samples are CIC transients and are valid data only from the third strobe onward; downstream discards them.

Simultaneous events:
- If enable falls on the same edge as a decimation tick, clear wins.

## Structure
- A shared package `sonar_pkg` holds the DSP constants: CIC_ORDER, PDM_DIV, PDM_DECIM, PCM_W, and the function `clog2`.
- The single natural sub-module is `pdm_clkgen` (divider, pdwClk register, bit-tick output). The CIC lives in the top of this block.

## Test plan
1. **Constant ones.** pdwData held at 1 → from the 3rd strobe, sample = 32767; strobes spaced exactly 1024 cycles.
2. **Constant zeros.** pdwData held at 0 → from the 3rd strobe, sample = −32768.
3. **Alternating bits.** pdwData toggled on each pdwClk falling edge → from the 3rd strobe, sample = 0. Also check the pdwClk period is 16 cycles, 8 high / 8 low.
4. **75%-density pattern.** Repeating 1,1,1,0 → settled sample = 16384 (±1).
5. **Enable dropped mid-frame.** Deassert enable at decCnt = 30 → pdwClk = 0 the next cycle, no strobe. After re-enable, the first strobe arrives 1027 cycles later.
6. **Reset mid-computation.** rstN asserted during the comb pipeline → all outputs read 0 immediately. After release, the test 1 behaviour recurs with identical timing.
